// File: rtl/glyph_pkg.sv
// Shared constants, types and helpers for the glyph pixel renderer.
// The progress-bar defaults are only used when GLYPH_PROGRESS_BAR_EN is defined.
package glyph_pkg;

    localparam logic [9:0] H_ACTIVE = 10'd640;
    localparam logic [9:0] V_ACTIVE = 10'd480;
    localparam int         H_TOTAL  = 800;
    localparam int         V_TOTAL  = 525;
    localparam int         GLYPH_W  = 8;

    localparam logic [7:0] FG_DEFAULT  = 8'hFF;
    localparam logic [7:0] BG_DEFAULT  = 8'h00;
    localparam logic [7:0] BAR_DEFAULT = 8'h1C;

    localparam logic [9:0] BAR_Y0_DEFAULT   = 10'd464;
    localparam logic [9:0] BAR_H            = 10'd8;
    localparam logic [9:0] BAR_STEP_DEFAULT = 10'd10;

    typedef enum logic {
        BLANK = 1'b0,
        DRAW  = 1'b1
    } state_t;

    typedef struct packed {
        logic       act;
        logic [9:0] hcnt;
        logic [9:0] vcnt;
    } coord_t;

    function automatic logic in_active(input logic [9:0] h, input logic [9:0] v);
        return (h < H_ACTIVE) && (v < V_ACTIVE);
    endfunction

endpackage

// File: rtl/glyph_pixel_render_if.sv
// Raster/ROM inputs and DAC-side outputs of the glyph pixel renderer.
// master drives counters, ROM data and progress count; slave is the renderer.
interface glyph_pixel_render_if;
    logic [9:0] hcnt;
    logic [9:0] vcnt;
    logic [7:0] rom_data;
    logic [5:0] prg_cnt;
    logic [7:0] rgb;
    logic       pix_valid;
    logic [9:0] hcnt_o;
    logic [9:0] vcnt_o;

    modport master (
        output hcnt, vcnt, rom_data, prg_cnt,
        input  rgb, pix_valid, hcnt_o, vcnt_o
    );

    modport slave (
        input  hcnt, vcnt, rom_data, prg_cnt,
        output rgb, pix_valid, hcnt_o, vcnt_o
    );
endinterface

// File: rtl/glyph_delay_line.sv
// DEPTH-stage pipe of {act, hcnt, vcnt} that lines the raster position up
// with the glyph ROM read latency.
module glyph_delay_line
    import glyph_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  coord_t din,
    output coord_t dout
);

    coord_t pipe [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/glyph_pixel_render.sv
// Serialises glyph ROM row words into one colour pixel per clock, blanking
// outside 640x480; progress-bar overlay compiled in with GLYPH_PROGRESS_BAR_EN.
//
//   state | meaning
//   BLANK | delayed position outside active area, shift register cleared
//   DRAW  | delayed position inside active area, pixels emitted
module glyph_pixel_render
    import glyph_pkg::*;
#(
    parameter int         ROM_LAT   = 2,
    parameter logic [7:0] FG_COLOR  = FG_DEFAULT,
    parameter logic [7:0] BG_COLOR  = BG_DEFAULT
`ifdef GLYPH_PROGRESS_BAR_EN
    ,
    parameter logic [7:0] BAR_COLOR = BAR_DEFAULT,
    parameter logic [9:0] BAR_Y0    = BAR_Y0_DEFAULT,
    parameter logic [9:0] BAR_STEP  = BAR_STEP_DEFAULT
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    glyph_pixel_render_if.slave  bus
);

    localparam int COL_BITS = $clog2(GLYPH_W);

    coord_t     din;
    coord_t     dd;
    state_t     state_q, state_d;
    logic [7:0] sr_q, sr_d;
    logic [7:0] rgb_q, rgb_d;
    logic       valid_q, valid_d;
    logic [9:0] hcnt_o_q, vcnt_o_q;
    logic       glyph_bit;
    logic       in_bar;
    logic       unused_sr_msb;

    assign din.act  = in_active(bus.hcnt, bus.vcnt);
    assign din.hcnt = bus.hcnt;
    assign din.vcnt = bus.vcnt;

    glyph_delay_line #(.DEPTH(ROM_LAT)) u_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .dout (dd)
    );

`ifdef GLYPH_PROGRESS_BAR_EN
    logic [9:0] bar_lim_q, bar_lim;

    // Bar length latched at the start of each delayed line so a prg_cnt
    // change mid-line only shows up on the following line.
    always_comb begin
        bar_lim = bar_lim_q;
        if (dd.hcnt == '0) begin
            bar_lim = {4'b0000, bus.prg_cnt} * BAR_STEP;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bar_lim_q <= '0;
        end else begin
            bar_lim_q <= bar_lim;
        end
    end

    assign in_bar = (dd.vcnt >= BAR_Y0) && (dd.vcnt < BAR_Y0 + BAR_H) &&
                    (dd.hcnt < bar_lim);
`else
    logic [5:0] unused_prg;
    assign unused_prg = bus.prg_cnt;
    assign in_bar     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BLANK;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        glyph_bit = 1'b0;
        rgb_d     = BG_COLOR;
        valid_d   = 1'b0;

        unique case (state_q)
            BLANK: if (dd.act)  state_d = DRAW;
            DRAW:  if (!dd.act) state_d = BLANK;
            default:            state_d = BLANK;
        endcase

        if (state_d == DRAW) begin
            // Load cycle takes its bit straight from the ROM so column
            // boundaries have no bubble.
            if (dd.hcnt[COL_BITS-1:0] == '0) begin
                sr_d      = bus.rom_data;
                glyph_bit = bus.rom_data[7];
            end else begin
                sr_d      = {sr_q[6:0], 1'b0};
                glyph_bit = sr_q[6];
            end
            valid_d = 1'b1;
`ifdef GLYPH_PROGRESS_BAR_EN
            if (in_bar) begin
                rgb_d = BAR_COLOR;
            end else
`endif
            if (glyph_bit) begin
                rgb_d = FG_COLOR;
            end
        end else begin
            sr_d = '0;
        end
    end

    assign unused_sr_msb = sr_q[7] | in_bar;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q     <= '0;
            rgb_q    <= BG_COLOR;
            valid_q  <= 1'b0;
            hcnt_o_q <= '0;
            vcnt_o_q <= '0;
        end else begin
            sr_q     <= sr_d;
            rgb_q    <= rgb_d;
            valid_q  <= valid_d;
            hcnt_o_q <= dd.hcnt;
            vcnt_o_q <= dd.vcnt;
        end
    end

    assign bus.rgb       = rgb_q;
    assign bus.pix_valid = valid_q;
    assign bus.hcnt_o    = hcnt_o_q;
    assign bus.vcnt_o    = vcnt_o_q;

endmodule

// File: tb/tb_glyph_pixel_render.sv
// Directed and randomized bench for glyph_pixel_render against a
// pixel-level reference model; bar expectations follow GLYPH_PROGRESS_BAR_EN.
module tb_glyph_pixel_render;

    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst;
    always #20 clk = ~clk;

    glyph_pixel_render_if bus ();

    glyph_pixel_render #(.ROM_LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit act;
        int h;
        int v;
    } crd_t;

    crd_t       q[$];
    logic [7:0] rom_tab [256];
    bit         rom_fix_en;
    logic [7:0] rom_fix;

    int         m_word, m_n, m_lim;
    logic [7:0] exp_rgb;
    logic       exp_valid;
    int         exp_h, exp_v;

    logic [7:0] seq_b [8] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    function automatic logic [7:0] rom_fn(int h, int v);
        if (rom_fix_en) return rom_fix;
        return rom_tab[((h / 8) + v * 13) % 256];
    endfunction

    task automatic chk(string tag, logic [9:0] obs, logic [9:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        crd_t z;
        z.act = 0; z.h = 0; z.v = 0;
        q.delete();
        for (int i = 0; i < LAT; i++) q.push_back(z);
        m_word = 0; m_n = 8; m_lim = 0;
        exp_rgb = 8'h00; exp_valid = 0; exp_h = 0; exp_v = 0;
    endtask

    // One pixel clock: drive inputs, advance the reference, compare after the edge.
    task automatic tick(int h, int v, int prg);
        crd_t c, d;
        int   bitv;
        bit   bar;
        bus.hcnt    = 10'(h);
        bus.vcnt    = 10'(v);
        bus.prg_cnt = 6'(prg);
        if (!rst) begin
            model_reset();
            bus.rom_data = rom_fn(0, 0);
        end else begin
            c.act = (h < 640) && (v < 480);
            c.h = h; c.v = v;
            d = q.pop_front();
            q.push_back(c);
            bus.rom_data = rom_fn(d.h, d.v);
            if (d.h == 0) m_lim = (prg * 10) % 1024;
            if (d.act) begin
                if (d.h % 8 == 0) begin
                    m_word = int'(bus.rom_data);
                    m_n = 0;
                end else if (m_n < 8) begin
                    m_n++;
                end
                bitv = (m_n < 8) ? ((m_word >> (7 - m_n)) & 1) : 0;
`ifdef GLYPH_PROGRESS_BAR_EN
                bar = (d.v >= 464) && (d.v < 472) && (d.h < m_lim);
`else
                bar = 0;
`endif
                exp_rgb   = bar ? 8'h1C : (bitv != 0 ? 8'hFF : 8'h00);
                exp_valid = 1;
            end else begin
                m_word = 0; m_n = 8;
                exp_rgb = 8'h00; exp_valid = 0;
            end
            exp_h = d.h; exp_v = d.v;
        end
        @(posedge clk);
        #1;
        chk("rgb",       {2'b00, bus.rgb},       {2'b00, exp_rgb});
        chk("pix_valid", {9'd0, bus.pix_valid},  {9'd0, exp_valid});
        chk("hcnt_o",    bus.hcnt_o,             10'(exp_h));
        chk("vcnt_o",    bus.vcnt_o,             10'(exp_v));
    endtask

    initial begin
        int h, v, prg, len;
        logic [7:0] e8;

        for (int i = 0; i < 256; i++) rom_tab[i] = 8'($urandom);
        rom_fix_en = 0; rom_fix = 8'h00;
        bus.hcnt = '0; bus.vcnt = '0; bus.rom_data = '0; bus.prg_cnt = '0;

        // Power-on reset values
        rst = 1'b0;
        model_reset();
        #3;
        chk("reset_rgb",   {2'b00, bus.rgb},      10'h000);
        chk("reset_valid", {9'd0, bus.pix_valid}, 10'h000);
        chk("reset_hcnt",  bus.hcnt_o,            10'h000);
        chk("reset_vcnt",  bus.vcnt_o,            10'h000);
        tick(0, 0, 0);
        rst = 1'b1;

        // Mid-frame reset released at h=100
        for (h = 80; h < 95; h++) tick(h, 20, 0);
        rst = 1'b0;
        for (h = 95; h < 100; h++) tick(h, 20, 0);
        rst = 1'b1;
        for (h = 100; h < 120; h++) begin
            tick(h, 20, 0);
            if (h <= 100 + LAT - 1) chk("rst_rel_blank", {9'd0, bus.pix_valid}, 10'd0);
            if (h - LAT >= 100 && h - LAT <= 103) begin
                chk("rst_rel_bg_valid", {9'd0, bus.pix_valid}, 10'd1);
                chk("rst_rel_bg_rgb",   {2'b00, bus.rgb},      10'h000);
            end
        end

        // Cell at h=0..7, v=0 with row word 1010_0000
        rom_fix_en = 1; rom_fix = 8'hA0;
        for (h = 795; h < 800; h++) tick(h, 524, 0);
        for (h = 0; h < 16; h++) begin
            tick(h, 0, 0);
            if (h >= LAT && h - LAT < 8) begin
                chk("seq_rgb",  {2'b00, bus.rgb}, {2'b00, seq_b[h-LAT]});
                chk("seq_hcnt", bus.hcnt_o,       10'(h - LAT));
            end
        end

        // Right edge of the active area
        rom_fix = 8'hFF;
        for (h = 632; h < 646; h++) begin
            tick(h, 10, 0);
            if (h - LAT >= 638 && h - LAT <= 641) begin
                e8 = (h - LAT < 640) ? 8'hFF : 8'h00;
                chk("edge_rgb",   {2'b00, bus.rgb},      {2'b00, e8});
                chk("edge_valid", {9'd0, bus.pix_valid}, (h - LAT < 640) ? 10'd1 : 10'd0);
            end
        end

        // Bottom edge: line 479 drawn, 480 blank
        for (h = 0; h < 12; h++) tick(h, 479, 0);
        for (h = 0; h < 12; h++) tick(h, 480, 0);

        // Bar with prg_cnt=5 on line 464, none on line 472
        rom_fix = 8'h00;
        for (h = 0; h < 60; h++) begin
            tick(h, 464, 5);
            if (h >= LAT) begin
`ifdef GLYPH_PROGRESS_BAR_EN
                e8 = (h - LAT < 50) ? 8'h1C : 8'h00;
`else
                e8 = 8'h00;
`endif
                chk("bar5_rgb", {2'b00, bus.rgb}, {2'b00, e8});
            end
        end
        for (h = 0; h < 60; h++) tick(h, 472, 5);

        // prg_cnt changes 5->20 mid-line on 465; takes effect on 466
        for (h = 0; h < 800; h++) tick(h, 465, (h < 300) ? 5 : 20);
        for (h = 0; h < 215; h++) tick(h, 466, 20);

        // prg_cnt extremes, full-on glyph data
        rom_fix = 8'hFF;
        for (h = 0; h < 640; h += 1) tick(h, 467, 63);
        for (h = 0; h < 20; h++) tick(h, 468, 0);

        // Randomized raster segments with random ROM contents and prg_cnt
        rom_fix_en = 0;
        for (int s = 0; s < 16; s++) begin
            case ($urandom_range(0, 2))
                0:       v = $urandom_range(0, 524);
                1:       v = 462 + $urandom_range(0, 11);
                default: v = 477 + $urandom_range(0, 4);
            endcase
            h   = $urandom_range(0, 799);
            len = $urandom_range(20, 120);
            prg = $urandom_range(0, 63);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 15) == 0) prg = $urandom_range(0, 63);
                tick(h, v, prg);
                h++;
                if (h == 800) begin
                    h = 0;
                    v = (v == 524) ? 0 : v + 1;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/glyph_pixel_render.md
# glyph_pixel_render

Downstream stage of the glyph address generator: consumes the 8-bit glyph row word returned by the glyph ROM for each character cell and serialises it into one colour pixel per clock. Keeps hcnt/vcnt aligned with ROM read latency, blanks outside the 640x480 active area and overlays the progress bar driven by prg_cnt. Output feeds the VGA colour DAC register directly.

## Interface
- ROM_LAT, 2, clocks from hcnt/vcnt presentation to rom_data valid (1..4)
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- BAR_Y0, 464, first line of progress bar (bar is 8 lines tall)
- BAR_STEP, 10, bar pixels per prg_cnt unit
- FG_COLOR, 8'hFF, glyph-on colour (RRRGGGBB)
- BG_COLOR, 8'h00, glyph-off colour
- BAR_COLOR, 8'h1C, progress bar colour

- clk  in  1  pixel clock (25 MHz)
- rst  in  1  asynchronous, active-low reset
- hcnt  in  10  horizontal counter, 0..799
- vcnt  in  10  vertical counter, 0..524
- rom_data  in  8  glyph row bits, bit 7 = leftmost pixel, valid ROM_LAT cycles after the matching hcnt/vcnt
- prg_cnt  in  6  progress count, 0..63
- rgb  out  8  pixel colour
- pix_valid  out  1  high when rgb belongs to the active area
- hcnt_o  out  10  hcnt aligned with rgb
- vcnt_o  out  10  vcnt aligned with rgb

## Operation
- Delay line: {act, hcnt, vcnt} pipelined ROM_LAT stages; act = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE), computed at input.
- Two-state FSM on delayed signals: BLANK (act_d = 0) and DRAW (act_d = 1). BLANK->DRAW when act_d rises; DRAW->BLANK when act_d falls.
- Shift register sr[7:0]: in DRAW, if hcnt_d[2:0] == 0 load rom_data, else shift left one, zero-fill. In BLANK, sr held at 0.
- Pixel select (registered): BLANK -> BG_COLOR, pix_valid 0. DRAW -> bar if in bar region, else FG_COLOR when glyph bit set, else BG_COLOR; pix_valid 1. Glyph bit is rom_data[7] on load cycles, sr[6] otherwise (no bubble on column boundaries).
- Bar region: BAR_Y0 <= vcnt_d < BAR_Y0+8 and hcnt_d < prg_cnt*BAR_STEP; product computed at 10 bits, prg_cnt sampled once per line at hcnt_d == 0 (no mid-line tearing).
- hcnt_o/vcnt_o = delayed counters registered with rgb.

## Timing
- Latency: rgb for coordinate (h,v) appears ROM_LAT+1 clocks after (h,v) is on hcnt/vcnt.
- Reset values: rgb = BG_COLOR, pix_valid = 0, hcnt_o = vcnt_o = 0, sr = 0, FSM = BLANK, all delay stages act = 0.
- Reset released mid-line: output stays blank until delay line refills (ROM_LAT+1 clocks); pixels before the next column boundary use sr = 0 (background).
- hcnt wrap 799->0: no special case; act recomputed per sample.
- Last active pixel h = 639 is drawn; h = 640 is blank. Same for v = 479 / 480.
- prg_cnt = 0: no bar pixels; prg_cnt = 63: bar spans h 0..629.
- prg_cnt change mid-line takes effect on the next line.

## Configuration
- GLYPH_PROGRESS_BAR_EN: defined -> bar overlay, BAR_* parameters and per-line prg_cnt sampling compiled in. Undefined -> prg_cnt ignored, bar region rendered as ordinary glyph pixels, no bar logic synthesised.

## Structure
- Package glyph_pkg: colour constants (FG/BG/BAR defaults), H_ACTIVE/V_ACTIVE, H_TOTAL = 800, V_TOTAL = 525, GLYPH_W = 8, FSM state enum {BLANK, DRAW}.
- Sub-module glyph_delay_line: parameterised ROM_LAT-deep pipe of {act, hcnt, vcnt}, async active-low reset to zero.

## Test plan
- Reset asserted mid-frame then released at h = 100: pix_valid 0 and rgb = 8'h00 for ROM_LAT+1 clocks, then BG until h_o = 104.
- rom_data model returning 8'b1010_0000 for cell at h = 0..7, v = 0: rgb sequence FF,00,FF,00,00,00,00,00 with hcnt_o 0..7, first pixel ROM_LAT+1 clocks after hcnt = 0.
- Sweep h = 638..641, v = 10 with rom_data = 8'hFF: rgb FF at 638, 639; 00 with pix_valid 0 at 640, 641.
- prg_cnt = 5, v = 464, rom_data = 0: rgb = 1C for h 0..49, 00 at h = 50; v = 472 shows no bar.
- prg_cnt changed 5->20 at h = 300 on v = 465: line 465 bar ends at h = 49, line 466 ends at h = 199.
- Build without GLYPH_PROGRESS_BAR_EN, prg_cnt = 63, v = 464, rom_data = 8'hFF: all active pixels FF.
